// File: rtl/crypto_itf_gen.sv
// Bus-side register interface for a crypto core: operand buffer, result capture,
// launch/timeout control FSM and a registered read port with a status word.
module crypto_itf_gen #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned IN_REG  = 34,
  parameter int unsigned OUT_REG = 9,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [4:0]               control,
  input  logic [WIDTH-1:0]         address,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     end_op,
  output logic [IN_REG*WIDTH-1:0]  core_din,
  input  logic [OUT_REG*WIDTH-1:0] core_dout,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     core_rst
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_t;

  localparam int unsigned      CNT_W    = 24;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] IN_LIM   = WIDTH'(IN_REG);
  localparam logic [WIDTH-1:0] OUT_LIM  = WIDTH'(OUT_REG);

  logic start, rd, load, rst_itf, srst;
  assign {start, rd, load, rst_itf, srst} = control;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               wr_err_q, wr_err_d;
  logic               addr_err_q, addr_err_d;
  logic               core_start_q, core_start_d;
  logic               core_rst_q, core_rst_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [WIDTH-1:0]   in_q  [IN_REG];
  logic [WIDTH-1:0]   in_d  [IN_REG];
  logic [WIDTH-1:0]   res_q [OUT_REG];
  logic [WIDTH-1:0]   res_d [OUT_REG];
  logic [WIDTH-1:0]   status;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    wr_err_d     = wr_err_q;
    addr_err_d   = addr_err_q;
    core_start_d = 1'b0;
    core_rst_d   = 1'b0;
    dout_d       = dout_q;
    in_d         = in_q;
    res_d        = res_q;
    status       = '0;
    status[4:0]  = {state_q == RUN, state_q == DONE, timeout_q, wr_err_q, addr_err_q};

    // All decisions below look only at *_q values, so mixed commands see pre-edge state
    if (load) begin
      if (address >= IN_LIM) addr_err_d = 1'b1;
      if (state_q == RUN) begin
        wr_err_d = 1'b1;
      end else if (state_q == IDLE || state_q == DONE) begin
        for (int unsigned k = 0; k < IN_REG; k++)
          if (address == WIDTH'(k)) in_d[k] = data_in;
      end
    end
    if (rst_itf)
      for (int unsigned k = 0; k < IN_REG; k++) in_d[k] = '0;

    if (rd) begin
      dout_d = '0;
      if (address < OUT_LIM) begin
        for (int unsigned k = 0; k < OUT_REG; k++)
          if (address == WIDTH'(k)) dout_d = res_q[k];
      end else if (address == OUT_LIM) begin
        dout_d = status;
      end else begin
        addr_err_d = 1'b1;
      end
    end

    case (state_q)
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done) begin
          for (int unsigned k = 0; k < OUT_REG; k++)
            res_d[k] = core_dout[k*WIDTH +: WIDTH];
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = TOUT;
          timeout_d  = 1'b1;
          core_rst_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d      = RUN;
          cnt_d        = '0;
          timeout_d    = 1'b0;
          core_start_d = 1'b1;
        end
      end
    endcase

    if (srst) begin
      state_d      = IDLE;
      cnt_d        = '0;
      timeout_d    = 1'b0;
      wr_err_d     = 1'b0;
      addr_err_d   = 1'b0;
      core_start_d = 1'b0;
      core_rst_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b1;
      dout_q       <= '0;
      for (int unsigned k = 0; k < IN_REG; k++)  in_q[k]  <= '0;
      for (int unsigned k = 0; k < OUT_REG; k++) res_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      wr_err_q     <= wr_err_d;
      addr_err_q   <= addr_err_d;
      core_start_q <= core_start_d;
      core_rst_q   <= core_rst_d;
      dout_q       <= dout_d;
      in_q         <= in_d;
      res_q        <= res_d;
    end
  end

  for (genvar g = 0; g < IN_REG; g++) begin : g_din
    assign core_din[g*WIDTH +: WIDTH] = in_q[g];
  end

  assign data_out   = dout_q;
  assign end_op     = (state_q == DONE);
  assign core_start = core_start_q;
  assign core_rst   = core_rst_q;

endmodule

// File: tb/tb_crypto_itf_gen.sv
// Directed bench for crypto_itf_gen: read expectations are queued when a read is
// issued and compared once the registered read data appears.
module tb_crypto_itf_gen;

  localparam int unsigned W       = 64;
  localparam int unsigned IN_REG  = 34;
  localparam int unsigned OUT_REG = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 i_rst;
  logic                 start, rd, load, rst_itf, srst;
  logic [4:0]           control;
  logic [W-1:0]         address, data_in;
  logic [W-1:0]         data_out, data_out_t;
  logic                 end_op, end_op_t;
  logic [IN_REG*W-1:0]  core_din, core_din_t;
  logic [OUT_REG*W-1:0] core_dout;
  logic                 core_start, core_start_t;
  logic                 core_done, core_done_t;
  logic                 core_rst, core_rst_t;

  assign control = {start, rd, load, rst_itf, srst};

  crypto_itf_gen #(.WIDTH(W), .IN_REG(IN_REG), .OUT_REG(OUT_REG), .TIMEOUT(65535)) dut (
    .clk(clk), .i_rst(i_rst), .control(control), .address(address), .data_in(data_in),
    .data_out(data_out), .end_op(end_op), .core_din(core_din), .core_dout(core_dout),
    .core_start(core_start), .core_done(core_done), .core_rst(core_rst)
  );

  crypto_itf_gen #(.WIDTH(W), .IN_REG(IN_REG), .OUT_REG(OUT_REG), .TIMEOUT(8)) dut_t (
    .clk(clk), .i_rst(i_rst), .control(control), .address(address), .data_in(data_in),
    .data_out(data_out_t), .end_op(end_op_t), .core_din(core_din_t), .core_dout(core_dout),
    .core_start(core_start_t), .core_done(core_done_t), .core_rst(core_rst_t)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] din_m [IN_REG];
  logic [W-1:0] exp_q [$];
  int           which_q [$];
  string        tag_q [$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_din(input string tag);
    for (int unsigned k = 0; k < IN_REG; k++)
      check($sformatf("%s[%0d]", tag, k), core_din[k*W +: W], din_m[k]);
  endtask

  task automatic expect_rd(input int which, input logic [W-1:0] e, input string tag);
    exp_q.push_back(e);
    which_q.push_back(which);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [W-1:0] e;
    int           w;
    string        t;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      w = which_q.pop_front();
      t = tag_q.pop_front();
      check(t, (w == 0) ? data_out : data_out_t, e);
    end
  endtask

  task automatic do_read(input logic [W-1:0] a);
    rd = 1'b1; address = a;
    @(negedge clk);
    rd = 1'b0;
    drain();
  endtask

  task automatic load_word(input logic [W-1:0] a, input logic [W-1:0] d);
    load = 1'b1; address = a; data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic soft_rst();
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b0; start = 1'b0; rd = 1'b0; load = 1'b0; rst_itf = 1'b0; srst = 1'b0;
    address = '0; data_in = '0; core_done = 1'b0; core_done_t = 1'b0;
    for (int unsigned k = 0; k < OUT_REG; k++)
      core_dout[k*W +: W] = (k == 0) ? 64'h1234 : 64'hBEEF_0000 + 64'(k);
    for (int unsigned k = 0; k < IN_REG; k++) din_m[k] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", data_out, 64'd0);
    check("rst_end_op", 64'(end_op), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check_din("rst_din");
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_release_core_rst", 64'(core_rst), 64'd0);

    // Write, launch, completion after 10 cycles, result read
    load_word(3, 64'hA5);
    din_m[3] = 64'hA5;
    check_din("wr3");
    pulse_start();
    check("start_pulse", 64'(core_start), 64'd1);
    check("start_end_op", 64'(end_op), 64'd0);
    @(negedge clk);
    check("start_width", 64'(core_start), 64'd0);
    repeat (8) @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("done_end_op", 64'(end_op), 64'd1);
    expect_rd(0, 64'h1234, "rd_res0");
    do_read(0);
    address = 64'd5;
    @(negedge clk);
    check("rd_hold", data_out, 64'h1234);
    expect_rd(0, 64'h08, "status_done");
    do_read(OUT_REG);
    expect_rd(0, 64'hBEEF_0005, "rd_res5");
    do_read(5);

    // Load during RUN is rejected; soft reset keeps buffers
    pulse_start();
    load_word(3, 64'hFF);
    check_din("run_load");
    expect_rd(0, 64'h12, "status_wr_err");
    do_read(OUT_REG);
    soft_rst();
    check("srst_core_rst", 64'(core_rst), 64'd1);
    check("srst_end_op", 64'(end_op), 64'd0);
    @(negedge clk);
    check("srst_core_rst_width", 64'(core_rst), 64'd0);
    expect_rd(0, 64'h00, "status_after_srst");
    do_read(OUT_REG);
    expect_rd(0, 64'h1234, "res_kept");
    do_read(0);
    check_din("din_kept");

    // Address boundaries
    expect_rd(0, 64'h0, "rd_bad_addr");
    do_read(OUT_REG + 1);
    expect_rd(0, 64'h01, "status_addr_err_rd");
    do_read(OUT_REG);
    soft_rst();
    load_word(IN_REG, 64'h77);
    check_din("bad_load");
    expect_rd(0, 64'h01, "status_addr_err_ld");
    do_read(OUT_REG);
    soft_rst();

    // rst_itf beats a simultaneous load
    rst_itf = 1'b1; load = 1'b1; address = 64'd3; data_in = 64'h66;
    @(negedge clk);
    rst_itf = 1'b0; load = 1'b0;
    din_m[3] = '0;
    check_din("rst_itf");

    // Timeout after 8 RUN cycles on the short-timeout instance
    pulse_start();
    check("tout_start_pulse", 64'(core_start_t), 64'd1);
    for (int unsigned i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("tout_not_yet_%0d", i), 64'(core_rst_t), 64'd0);
    end
    @(negedge clk);
    check("tout_core_rst", 64'(core_rst_t), 64'd1);
    @(negedge clk);
    check("tout_core_rst_width", 64'(core_rst_t), 64'd0);
    expect_rd(1, 64'h04, "status_tout");
    expect_rd(0, 64'h10, "status_main_busy");
    do_read(OUT_REG);
    soft_rst();

    // core_done on the final timeout cycle: done wins
    pulse_start();
    repeat (7) @(negedge clk);
    core_done_t = 1'b1;
    @(negedge clk);
    core_done_t = 1'b0;
    check("coincide_done", 64'(end_op_t), 64'd1);
    check("coincide_no_rst", 64'(core_rst_t), 64'd0);
    expect_rd(1, 64'h08, "status_coincide");
    expect_rd(0, 64'h10, "status_main_busy2");
    do_read(OUT_REG);
    expect_rd(1, 64'h1234, "coincide_res0");
    expect_rd(0, 64'h1234, "main_res0");
    do_read(0);

    // Asynchronous reset in the middle of RUN
    soft_rst();
    load_word(7, 64'h55);
    din_m[7] = 64'h55;
    pulse_start();
    repeat (3) @(negedge clk);
    expect_rd(0, 64'h1234, "pre_arst");
    do_read(0);
    check_din("pre_arst_din");
    #2;
    i_rst = 1'b0;
    #1;
    for (int unsigned k = 0; k < IN_REG; k++) din_m[k] = '0;
    check("arst_dout", data_out, 64'd0);
    check("arst_end_op", 64'(end_op), 64'd0);
    check("arst_core_start", 64'(core_start), 64'd0);
    check("arst_core_rst", 64'(core_rst), 64'd1);
    check_din("arst_din");
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    expect_rd(0, 64'h0, "res_cleared");
    do_read(0);
    expect_rd(0, 64'h0, "status_cleared");
    do_read(OUT_REG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
